micro_waves_power_control: RTL and testbench
============================================

Name: micro_waves_power_control

Overview:
Next-generation microwave oven controller. It adds to the existing magnetron/timer/keypad scheme a parametrised minutes field, power-level duty cycling, and pause/resume on stop or door-open. It sits at nivel1, replacing the fixed-function control path, and drives BCD digits for the existing 7-segment decoder plus the magnetron enable. Its internal 1 Hz prescaler makes timing independent of any external pgt source.

Parameters:
CLK_HZ, 1000, clk cycles per second tick (>=2).
MIN_DIGITS, 1, number of BCD minute digits (1 or 2).
DUTY_PERIOD_S, 10, seconds per power-cycling window (>=10).

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
startn  in  1  start button, active-low, pre-debounced
stopn  in  1  stop/pause button, active-low
clearn  in  1  clear/cancel button, active-low
door_closed  in  1  1 = door closed
powern  in  1  active-low; when low, the next key press sets the power level
keyboard  in  10  one-hot digit keys 0..9, level
min_bcd  out  4*MIN_DIGITS  minute digits, BCD, most significant digit first
sec_tens  out  4  BCD 0..9 (entry may exceed 5)
sec_ones  out  4  BCD
power_level  out  4  1..10
mag_on  out  1  magnetron enable
cooking  out  1  high in COOK and PAUSE
done  out  1  one-cycle pulse when countdown reaches 0:00

Behaviour:
- Reset (async, resetn=0): state IDLE; all digits 0; power_level=10; mag_on=0; cooking=0; done=0; prescaler=0; window counter=0.
- Buttons act on the registered falling edge: previous=1 and current=0, sampled in the same clk.
- Key press: rising edge of keyboard while exactly one bit is high. Multiple bits high means the press is ignored.
- Priority within one cycle: clearn > door opening > stopn > startn > key.
- FSM states: IDLE, SET, COOK, PAUSE.
  - IDLE, on key: digit entry; go to SET.
  - SET, on key: digit entry.
  - SET, on start with door_closed=1 and time nonzero: go to COOK; prescaler and window counter reset.
  - IDLE/SET, on start with door open or time zero: ignored.
  - COOK, on stop edge or door_closed=0: go to PAUSE; time frozen; mag_on=0 on the next cycle.
  - PAUSE, on start with door_closed=1: go to COOK; prescaler resets, so a full second elapses before the next decrement.
  - PAUSE, on stop: go to IDLE; digits cleared.
  - Any state, on clear: go to IDLE; digits 0; power_level=10.
- Digit entry: new digit enters sec_ones; sec_ones shifts to sec_tens, sec_tens to min_ones, and so on up to the top minute digit. The top minute digit is discarded.
- Power entry: a key with powern=0 in IDLE/SET sets power_level to the key value (key 0 means 10). The digits are unchanged.
- Countdown, one step per tick in COOK, where tick is a 1-cycle pulse every CLK_HZ cycles:
  - sec_ones>0: decrement sec_ones.
  - Otherwise, if sec_tens>0: sec_tens-1, sec_ones=9.
  - Otherwise, if minutes>0: sec_tens=5, sec_ones=9, minutes decremented as BCD with borrow.
  - Entered 0:90 therefore runs 90 s.
- On the tick that yields all zeros: done=1 for that cycle, go to IDLE; power_level is retained.
- Duty cycling: a window counter of 0..DUTY_PERIOD_S-1 advances on each tick in COOK.
  - mag_on = (state==COOK) && (window < power_level), registered.
  - power_level=10 with DUTY_PERIOD_S=10 gives continuous operation.
  - PAUSE freezes the window counter.
- Door opening takes effect in the same cycle it is sampled, including a cycle that also carries a tick. The tick is then discarded.

Optional Feature:
DONE_BEEP_EN.
- Defined: adds output port beep (1 bit). beep=1 for 3 ticks after done, counted by the prescaler, which keeps running in IDLE while beeping. Any button edge or key clears beep immediately.
- Undefined: no beep port and no beep counter; done is the only completion indication.

Decomposition:
- Package micro_waves_pkg holds:
  - state enum (IDLE, SET, COOK, PAUSE);
  - bcd_t (4-bit) type;
  - constants PWR_MAX=10 and BEEP_TICKS=3.
- Sub-module tick_gen_1hz (parameter CLK_HZ; inputs clk, resetn, sync clear, enable; output 1-cycle tick pulse). It is instantiated once.

Test Plan:
- CLK_HZ=4: keys 1,3,0 then start with door closed -> digits 1:30; mag_on=1 next cycle; after 4 clks 1:29; after 90 ticks done pulse, state IDLE, mag_on=0.
- Keys 9,0, start -> counts 0:90, 0:89 … 0:80, then 0:79; total 90 ticks to done.
- powern=0 + key 3, then keys 2,0, start -> mag_on high for ticks 0–2 and low for ticks 3–9 of each 10-tick window; done after 20 ticks.
- Door opens at 0:15 -> mag_on=0 next cycle and time frozen for 50 clks; door closed, start -> resumes at 0:15, first decrement exactly 4 clks later.
- clearn during COOK concurrent with a start edge -> IDLE, digits 0, power_level=10. Start with 0:00 or door open -> no state change.
- resetn asserted mid-COOK asynchronously -> all outputs at reset values before the next clk edge. With DONE_BEEP_EN, beep is high for 12 clks after done.

Source files
------------

// File: rtl/micro_waves_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | micro_waves_pkg : shared types and constants for the oven controller |
// | Rev 1.0                                                              |
// +---------------------------------------------------------------------+
package micro_waves_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET   = 2'd1,
        COOK  = 2'd2,
        PAUSE = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t PWR_MAX    = 4'd10;
    localparam int   BEEP_TICKS = 3;

    // Key 0 selects full power, other keys select their own value.
    function automatic bcd_t key_to_power(input bcd_t key);
        return (key == 4'd0) ? PWR_MAX : key;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen_1hz.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | tick_gen_1hz : one-cycle tick every CLK_HZ enabled clocks            |
// | Rev 1.0                                                              |
// +---------------------------------------------------------------------+
module tick_gen_1hz #(
    parameter int CLK_HZ = 1000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int                CNT_W    = $clog2(CLK_HZ);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable && (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/micro_waves_power_control.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | micro_waves_power_control : oven timer, power duty cycling, pause    |
// | Optional macro DONE_BEEP_EN adds the beep output. Rev 1.0            |
// +---------------------------------------------------------------------+
module micro_waves_power_control
    import micro_waves_pkg::*;
#(
    parameter int CLK_HZ        = 1000,
    parameter int MIN_DIGITS    = 1,
    parameter int DUTY_PERIOD_S = 10
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    startn,
    input  logic                    stopn,
    input  logic                    clearn,
    input  logic                    door_closed,
    input  logic                    powern,
    input  logic [9:0]              keyboard,
    output logic [4*MIN_DIGITS-1:0] min_bcd,
    output logic [3:0]              sec_tens,
    output logic [3:0]              sec_ones,
    output logic [3:0]              power_level,
    output logic                    mag_on,
    output logic                    cooking,
    output logic                    done
`ifdef DONE_BEEP_EN
    ,
    output logic                    beep
`endif
);
    localparam int               MW       = 4 * MIN_DIGITS;
    localparam int               WIN_W    = $clog2(DUTY_PERIOD_S);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(DUTY_PERIOD_S - 1);

    state_t           state_q, state_d;
    logic [MW-1:0]    min_q, min_d;
    bcd_t             tens_q, tens_d, ones_q, ones_d, pwr_q, pwr_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic             mag_q, mag_d, done_q, done_d;
    logic             startn_q, stopn_q, clearn_q;
    logic [9:0]       kb_q;
    logic             start_edge, stop_edge, clear_edge, key_hit;
    bcd_t             key_val;
    logic             presc_clr, presc_en, tick, time_nz, borrow;

    assign start_edge = startn_q & ~startn;
    assign stop_edge  = stopn_q  & ~stopn;
    assign clear_edge = clearn_q & ~clearn;
    assign key_hit    = ((keyboard & ~kb_q) != '0) && $onehot(keyboard);
    assign time_nz    = (min_q != '0) || (tens_q != '0) || (ones_q != '0);

    always_comb begin
        key_val = '0;
        for (int i = 0; i < 10; i++) begin
            if (keyboard[i]) key_val = 4'(i);
        end
    end

    tick_gen_1hz #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .clear  (presc_clr || done_d),
        .enable (presc_en),
        .tick   (tick)
    );

    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        pwr_d     = pwr_q;
        win_d     = win_q;
        done_d    = 1'b0;
        presc_clr = 1'b0;
        borrow    = 1'b0;
        if (clear_edge) begin
            state_d = IDLE;
            min_d   = '0;
            tens_d  = '0;
            ones_d  = '0;
            pwr_d   = PWR_MAX;
        end else begin
            case (state_q)
                IDLE, SET: begin
                    if (start_edge) begin
                        if (state_q == SET && door_closed && time_nz) begin
                            state_d   = COOK;
                            win_d     = '0;
                            presc_clr = 1'b1;
                        end
                    end else if (key_hit) begin
                        if (!powern) begin
                            pwr_d = key_to_power(key_val);
                        end else begin
                            min_d   = (min_q << 4) | MW'(tens_q);
                            tens_d  = ones_q;
                            ones_d  = key_val;
                            state_d = SET;
                        end
                    end
                end
                COOK: begin
                    // An opening door wins over a coincident tick, which is dropped.
                    if (!door_closed || stop_edge) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        if (ones_q != 4'd0) begin
                            ones_d = ones_q - 4'd1;
                        end else if (tens_q != 4'd0) begin
                            tens_d = tens_q - 4'd1;
                            ones_d = 4'd9;
                        end else if (min_q != '0) begin
                            tens_d = 4'd5;
                            ones_d = 4'd9;
                            borrow = 1'b1;
                            for (int i = 0; i < MIN_DIGITS; i++) begin
                                if (borrow) begin
                                    if (min_q[4*i +: 4] == 4'd0) begin
                                        min_d[4*i +: 4] = 4'd9;
                                    end else begin
                                        min_d[4*i +: 4] = min_q[4*i +: 4] - 4'd1;
                                        borrow          = 1'b0;
                                    end
                                end
                            end
                        end
                        win_d = (win_q == WIN_LAST) ? '0 : win_q + 1'b1;
                        if ({min_d, tens_d, ones_d} == '0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (stop_edge) begin
                        state_d = IDLE;
                        min_d   = '0;
                        tens_d  = '0;
                        ones_d  = '0;
                    end else if (start_edge && door_closed) begin
                        state_d   = COOK;
                        presc_clr = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        mag_d = (state_d == COOK) && (win_d < WIN_W'(pwr_d));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            min_q    <= '0;
            tens_q   <= '0;
            ones_q   <= '0;
            pwr_q    <= PWR_MAX;
            win_q    <= '0;
            mag_q    <= 1'b0;
            done_q   <= 1'b0;
            startn_q <= 1'b1;
            stopn_q  <= 1'b1;
            clearn_q <= 1'b1;
            kb_q     <= '0;
        end else begin
            state_q  <= state_d;
            min_q    <= min_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            pwr_q    <= pwr_d;
            win_q    <= win_d;
            mag_q    <= mag_d;
            done_q   <= done_d;
            startn_q <= startn;
            stopn_q  <= stopn;
            clearn_q <= clearn;
            kb_q     <= keyboard;
        end
    end

`ifdef DONE_BEEP_EN
    logic [1:0] beep_q, beep_d;

    always_comb begin
        beep_d = beep_q;
        if (start_edge || stop_edge || clear_edge || key_hit) begin
            beep_d = '0;
        end else if (done_d) begin
            beep_d = 2'(BEEP_TICKS);
        end else if (tick && state_q != COOK && beep_q != '0) begin
            beep_d = beep_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beep_q <= '0;
        end else begin
            beep_q <= beep_d;
        end
    end

    assign beep     = (beep_q != '0);
    assign presc_en = (state_q == COOK) || beep;
`else
    assign presc_en = (state_q == COOK);
`endif

    assign min_bcd     = min_q;
    assign sec_tens    = tens_q;
    assign sec_ones    = ones_q;
    assign power_level = pwr_q;
    assign mag_on      = mag_q;
    assign done        = done_q;
    assign cooking     = (state_q == COOK) || (state_q == PAUSE);

endmodule
`default_nettype wire

// File: tb/tb_micro_waves_power_control.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | tb_micro_waves_power_control : self-checking bench, CLK_HZ = 4       |
// | Rev 1.0                                                              |
// +---------------------------------------------------------------------+
module tb_micro_waves_power_control;
    localparam int CLK_HZ = 4;
    localparam int DUTY   = 10;

    logic       clk = 1'b0, resetn = 1'b0, startn = 1'b1, stopn = 1'b1, clearn = 1'b1;
    logic       door_closed = 1'b1, powern = 1'b1;
    logic [9:0] keyboard = '0;
    logic [3:0] min_bcd, sec_tens, sec_ones, power_level;
    logic       mag_on, cooking, done;
`ifdef DONE_BEEP_EN
    logic       beep;
`endif
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    micro_waves_power_control #(.CLK_HZ(CLK_HZ), .MIN_DIGITS(1), .DUTY_PERIOD_S(DUTY)) dut (
        .clk(clk), .resetn(resetn), .startn(startn), .stopn(stopn), .clearn(clearn),
        .door_closed(door_closed), .powern(powern), .keyboard(keyboard),
        .min_bcd(min_bcd), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .power_level(power_level), .mag_on(mag_on), .cooking(cooking), .done(done)
`ifdef DONE_BEEP_EN
        , .beep(beep)
`endif
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_key(input int k, input bit pwr);
        powern      = ~pwr;
        keyboard    = '0;
        keyboard[k] = 1'b1;
        step(1);
        keyboard    = '0;
        powern      = 1'b1;
        step(1);
    endtask

    task automatic press_clear();
        clearn = 1'b0; step(1); clearn = 1'b1; step(1);
    endtask

    // Expected display after s elapsed seconds, from remaining-time arithmetic.
    function automatic logic [11:0] disp(input int m, input int t, input int o, input int s);
        int r, sp;
        r = m * 60 + t * 10 + o - s;
        if (r >= m * 60) begin
            sp = r - m * 60;
            return {4'(m), 4'(sp / 10), 4'(sp % 10)};
        end
        return {4'(r / 60), 4'((r % 60) / 10), 4'(r % 10)};
    endfunction

    task automatic cook_run(input int m, input int t, input int o, input int pwr, input string tag);
        int total, s;
        logic [11:0] exp_d;
        logic exp_mag;
        bit bad;
        total = m * 60 + t * 10 + o;
        bad = 0;
        startn = 1'b0; step(1); startn = 1'b1;
        checks++;
        if (mag_on !== 1'b1 || cooking !== 1'b1) begin
            failures++;
            $display("FAIL %s_start mag=%b cook=%b required 1 1", tag, mag_on, cooking);
        end
        for (int c = 1; c <= CLK_HZ * total && !bad; c++) begin
            step(1);
            s = c / CLK_HZ;
            exp_d = disp(m, t, o, s);
            exp_mag = (c < CLK_HZ * total) && ((s % DUTY) < pwr);
            checks++;
            if ({min_bcd, sec_tens, sec_ones} !== exp_d || mag_on !== exp_mag ||
                done !== (c == CLK_HZ * total) || cooking !== (c < CLK_HZ * total)) begin
                failures++;
                bad = 1;
                $display("FAIL %s_clk%0d time=%h req=%h mag=%b req=%b done=%b cook=%b",
                         tag, c, {min_bcd, sec_tens, sec_ones}, exp_d, mag_on, exp_mag, done, cooking);
            end
        end
        step(1);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_pulse done=%b required 0", tag, done);
        end
    endtask

    task automatic test_reset();
        step(2);
        checks++;
        if ({min_bcd, sec_tens, sec_ones} !== 12'h000 || power_level !== 4'd10 ||
            mag_on !== 1'b0 || cooking !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_values time=%h pwr=%0d mag=%b cook=%b done=%b",
                     {min_bcd, sec_tens, sec_ones}, power_level, mag_on, cooking, done);
        end
`ifdef DONE_BEEP_EN
        checks++;
        if (beep !== 1'b0) begin
            failures++;
            $display("FAIL reset_beep beep=%b required 0", beep);
        end
`endif
        resetn = 1'b1;
        step(1);
    endtask

    task automatic test_countdown();
        int c;
        bit seen;
        press_key(1, 0); press_key(3, 0); press_key(0, 0);
        checks++;
        if ({min_bcd, sec_tens, sec_ones} !== 12'h130) begin
            failures++;
            $display("FAIL entry_130 time=%h required 130", {min_bcd, sec_tens, sec_ones});
        end
        startn = 1'b0; step(1); startn = 1'b1;
        checks++;
        if (mag_on !== 1'b1 || cooking !== 1'b1) begin
            failures++;
            $display("FAIL start_mag mag=%b cook=%b required 1 1", mag_on, cooking);
        end
        step(3);
        checks++;
        if ({min_bcd, sec_tens, sec_ones} !== 12'h130) begin
            failures++;
            $display("FAIL hold_3clk time=%h required 130", {min_bcd, sec_tens, sec_ones});
        end
        step(1);
        checks++;
        if ({min_bcd, sec_tens, sec_ones} !== 12'h129) begin
            failures++;
            $display("FAIL first_tick time=%h required 129", {min_bcd, sec_tens, sec_ones});
        end
        c = 4;
        seen = 0;
        while (!seen && c < 400) begin
            step(1);
            c++;
            if (done === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || c != 90 * CLK_HZ) begin
            failures++;
            $display("FAIL done_time clk=%0d seen=%0d required %0d", c, seen, 90 * CLK_HZ);
        end
        checks++;
        if (cooking !== 1'b0 || mag_on !== 1'b0 || {min_bcd, sec_tens, sec_ones} !== 12'h000) begin
            failures++;
            $display("FAIL done_state cook=%b mag=%b time=%h required 0 0 000",
                     cooking, mag_on, {min_bcd, sec_tens, sec_ones});
        end
        step(1);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_one_cycle done=%b required 0", done);
        end
    endtask

    task automatic test_ninety();
        press_key(9, 0); press_key(0, 0);
        cook_run(0, 9, 0, 10, "ninety");
    endtask

    task automatic test_power_duty();
        press_key(3, 1);
        checks++;
        if (power_level !== 4'd3 || {min_bcd, sec_tens, sec_ones} !== 12'h000) begin
            failures++;
            $display("FAIL power_entry pwr=%0d time=%h required 3 000", power_level, {min_bcd, sec_tens, sec_ones});
        end
        press_key(2, 0); press_key(0, 0);
        cook_run(0, 2, 0, 3, "duty");
    endtask

    task automatic test_door_pause();
        press_clear();
        press_key(3, 0); press_key(0, 0);
        startn = 1'b0; step(1); startn = 1'b1;
        step(60);
        checks++;
        if ({min_bcd, sec_tens, sec_ones} !== 12'h015 || mag_on !== 1'b1) begin
            failures++;
            $display("FAIL door_pre time=%h mag=%b required 015 1", {min_bcd, sec_tens, sec_ones}, mag_on);
        end
        door_closed = 1'b0; step(1);
        checks++;
        if (mag_on !== 1'b0 || cooking !== 1'b1) begin
            failures++;
            $display("FAIL door_open mag=%b cook=%b required 0 1", mag_on, cooking);
        end
        step(50);
        checks++;
        if ({min_bcd, sec_tens, sec_ones} !== 12'h015 || mag_on !== 1'b0) begin
            failures++;
            $display("FAIL door_frozen time=%h mag=%b required 015 0", {min_bcd, sec_tens, sec_ones}, mag_on);
        end
        door_closed = 1'b1; step(2);
        startn = 1'b0; step(1); startn = 1'b1;
        checks++;
        if (mag_on !== 1'b1 || cooking !== 1'b1) begin
            failures++;
            $display("FAIL resume_mag mag=%b cook=%b required 1 1", mag_on, cooking);
        end
        step(3);
        checks++;
        if ({min_bcd, sec_tens, sec_ones} !== 12'h015) begin
            failures++;
            $display("FAIL resume_hold time=%h required 015", {min_bcd, sec_tens, sec_ones});
        end
        step(1);
        checks++;
        if ({min_bcd, sec_tens, sec_ones} !== 12'h014) begin
            failures++;
            $display("FAIL resume_tick time=%h required 014", {min_bcd, sec_tens, sec_ones});
        end
        step(3);
        door_closed = 1'b0; step(1);
        checks++;
        if ({min_bcd, sec_tens, sec_ones} !== 12'h014 || mag_on !== 1'b0) begin
            failures++;
            $display("FAIL door_on_tick time=%h mag=%b required 014 0", {min_bcd, sec_tens, sec_ones}, mag_on);
        end
        door_closed = 1'b1;
        stopn = 1'b0; step(1); stopn = 1'b1; step(1);
        checks++;
        if (cooking !== 1'b0 || {min_bcd, sec_tens, sec_ones} !== 12'h000) begin
            failures++;
            $display("FAIL pause_stop cook=%b time=%h required 0 000", cooking, {min_bcd, sec_tens, sec_ones});
        end
    endtask

    task automatic test_clear_priority();
        press_key(5, 1);
        press_key(2, 0); press_key(5, 0);
        startn = 1'b0; step(1); startn = 1'b1;
        step(6);
        clearn = 1'b0; startn = 1'b0; step(1); clearn = 1'b1; startn = 1'b1;
        checks++;
        if (cooking !== 1'b0 || mag_on !== 1'b0 || power_level !== 4'd10 ||
            {min_bcd, sec_tens, sec_ones} !== 12'h000) begin
            failures++;
            $display("FAIL clear_cook cook=%b mag=%b pwr=%0d time=%h required 0 0 10 000",
                     cooking, mag_on, power_level, {min_bcd, sec_tens, sec_ones});
        end
        step(1);
        press_key(4, 0);
        clearn = 1'b0; keyboard = 10'b0010000000; step(1);
        clearn = 1'b1; keyboard = '0; step(1);
        checks++;
        if ({min_bcd, sec_tens, sec_ones} !== 12'h000) begin
            failures++;
            $display("FAIL clear_vs_key time=%h required 000", {min_bcd, sec_tens, sec_ones});
        end
    endtask

    task automatic test_start_ignored();
        startn = 1'b0; step(1); startn = 1'b1; step(1);
        checks++;
        if (cooking !== 1'b0) begin
            failures++;
            $display("FAIL start_zero cook=%b required 0", cooking);
        end
        press_key(5, 0);
        door_closed = 1'b0;
        startn = 1'b0; step(1); startn = 1'b1; step(1);
        checks++;
        if (cooking !== 1'b0 || {min_bcd, sec_tens, sec_ones} !== 12'h005) begin
            failures++;
            $display("FAIL start_door_open cook=%b time=%h required 0 005", cooking, {min_bcd, sec_tens, sec_ones});
        end
        door_closed = 1'b1;
        keyboard = 10'b0000001100; step(1); keyboard = '0; step(1);
        checks++;
        if ({min_bcd, sec_tens, sec_ones} !== 12'h005) begin
            failures++;
            $display("FAIL multi_key time=%h required 005", {min_bcd, sec_tens, sec_ones});
        end
        press_clear();
    endtask

    task automatic test_random();
        int k, pwr, m, t, o;
        for (int it = 0; it < 6; it++) begin
            k   = $urandom_range(0, 9);
            pwr = (k == 0) ? 10 : k;
            m   = ($urandom_range(0, 3) == 0) ? 1 : 0;
            t   = $urandom_range(0, 9);
            o   = $urandom_range(0, 9);
            if (m == 0 && t == 0 && o == 0) o = 1;
            press_key(k, 1);
            if (m != 0) press_key(m, 0);
            press_key(t, 0);
            press_key(o, 0);
            checks++;
            if (power_level !== 4'(pwr) || {min_bcd, sec_tens, sec_ones} !== {4'(m), 4'(t), 4'(o)}) begin
                failures++;
                $display("FAIL rand_entry%0d pwr=%0d time=%h required %0d %h",
                         it, power_level, {min_bcd, sec_tens, sec_ones}, pwr, {4'(m), 4'(t), 4'(o)});
            end
            cook_run(m, t, o, pwr, "rand");
        end
    endtask

    task automatic test_async_reset();
        press_key(7, 1);
        press_key(4, 0); press_key(5, 0);
        startn = 1'b0; step(1); startn = 1'b1;
        step(6);
        #3;
        resetn = 1'b0;
        #1;
        checks++;
        if ({min_bcd, sec_tens, sec_ones} !== 12'h000 || power_level !== 4'd10 ||
            mag_on !== 1'b0 || cooking !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset time=%h pwr=%0d mag=%b cook=%b done=%b",
                     {min_bcd, sec_tens, sec_ones}, power_level, mag_on, cooking, done);
        end
        #2;
        resetn = 1'b1;
        step(1);
    endtask

`ifdef DONE_BEEP_EN
    task automatic test_beep();
        int c, n;
        press_key(1, 0);
        startn = 1'b0; step(1); startn = 1'b1;
        c = 0;
        while (done !== 1'b1 && c < 50) begin
            step(1);
            c++;
        end
        n = 0;
        while (beep === 1'b1 && n < 40) begin
            n++;
            step(1);
        end
        checks++;
        if (c >= 50 || n != 3 * CLK_HZ) begin
            failures++;
            $display("FAIL beep_len beep_clks=%0d required %0d (wait=%0d)", n, 3 * CLK_HZ, c);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_countdown();
        test_ninety();
        test_power_duty();
        test_door_pause();
        test_clear_priority();
        test_start_ignored();
        test_random();
        test_async_reset();
`ifdef DONE_BEEP_EN
        test_beep();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
